// File: rtl/hcsr04_pkg.sv
// -----------------------------------------------------------------------------
// hcsr04_pkg
//
// Shared definitions for the HC-SR04 echo emulator and for sensor_driver:
//   - state_t   : emulator FSM states
//   - *_DEF     : 50 MHz default timing constants and distance limits
//   - max3()    : helper used to size the shared down/up counters
// -----------------------------------------------------------------------------
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    // Timing at 50 MHz
    localparam int TRIG_MIN_CYC_DEF  = 500;      // 10 us minimum trigger
    localparam int BURST_DLY_CYC_DEF = 10000;    // 200 us burst delay
    localparam int CYC_PER_CM_DEF    = 2900;     // 58 us per centimetre
    localparam int TIMEOUT_CYC_DEF   = 1900000;  // 38 ms no-object echo
    localparam int HOLDOFF_CYC_DEF   = 500000;   // 10 ms re-arm dead time

    // Distance limits
    localparam int MIN_CM_DEF        = 2;
    localparam int MAX_CM_DEF        = 400;
    localparam int DIST_W_DEF        = 9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : hcsr04_pkg

// File: rtl/hcsr04_echo_emulator_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//
// Two-flop synchronizer for an asynchronous input followed by a registered
// copy used for edge detection. Reusable for GPIO echo and KEY inputs.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (all flops clear to 0)
//   din    in   asynchronous input
//   level  out  synchronized level
//   rise   out  high for one cycle after level goes 0 -> 1
//   fall   out  high for one cycle after level goes 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    // Both operands are flops, so the decoded edges are glitch-free.
    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule : sync_edge

// File: rtl/hcsr04_echo_emulator.sv
// -----------------------------------------------------------------------------
// hcsr04_echo_emulator
//
// Responder side of the HC-SR04 trigger/echo protocol. A trigger of at least
// TRIG_MIN_CYC synchronized cycles is accepted on its falling edge; after a
// fixed burst delay an echo pulse is driven whose width is
// max(distance, MIN_CM) * CYC_PER_CM cycles, or TIMEOUT_CYC when no object
// is present or the distance exceeds MAX_CM. A holdoff follows each echo.
//
// Ports:
//   clk            in   system clock (50 MHz)
//   rst_n          in   asynchronous active-low reset
//   trig           in   trigger from driver, asynchronous
//   distance_cm    in   target distance, sampled at trigger acceptance
//   object_present in   0 forces a timeout echo, sampled with distance_cm
//   echo           out  registered echo pulse
//   busy           out  high from trigger acceptance until end of holdoff
//   short_trig     out  one-cycle pulse when a trigger is too short
//   trig_ignored   out  one-cycle pulse on a trigger rise while busy
//   meas_count     out  completed echoes, wrapping 16-bit count
//
// Timing (cycle 0 = edge where the first synchronizer flop captures trig=0):
//   edge 1            : synchronized level falls, fall strobe visible
//   edge 2            : trigger accepted, BURST entered, busy set
//   edge 3+BURST_DLY  : echo rises
// -----------------------------------------------------------------------------
module hcsr04_echo_emulator
    import hcsr04_pkg::*;
#(
    parameter int TRIG_MIN_CYC  = TRIG_MIN_CYC_DEF,
    parameter int BURST_DLY_CYC = BURST_DLY_CYC_DEF,
    parameter int CYC_PER_CM    = CYC_PER_CM_DEF,
    parameter int MIN_CM        = MIN_CM_DEF,
    parameter int MAX_CM        = MAX_CM_DEF,
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
    parameter int HOLDOFF_CYC   = HOLDOFF_CYC_DEF,
    parameter int DIST_W        = DIST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] distance_cm,
    input  logic              object_present,
    output logic              echo,
    output logic              busy,
    output logic              short_trig,
    output logic              trig_ignored,
    output logic [15:0]       meas_count
);

    // One general-purpose counter covers burst delay, timeout echo and
    // holdoff; it is wide enough for the largest of the three.
    localparam int MAX_CYC = max3(TIMEOUT_CYC, HOLDOFF_CYC, BURST_DLY_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int TW      = $clog2(TRIG_MIN_CYC + 1);
    localparam int SUB_W   = $clog2(CYC_PER_CM + 1);

    localparam logic [CNT_W-1:0]  BURST_LAST   = CNT_W'(BURST_DLY_CYC);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(CYC_PER_CM - 1);
    localparam logic [TW-1:0]     TRIG_MIN     = TW'(TRIG_MIN_CYC);
    localparam logic [DIST_W-1:0] DIST_MIN     = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] DIST_MAX     = DIST_W'(MAX_CM);

    // -------------------------------------------------------------------------
    // Trigger synchronizer and edge detect
    // -------------------------------------------------------------------------
    logic trig_level;
    logic trig_rise;
    logic trig_fall;

    sync_edge u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (trig),
        .level (trig_level),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SUB_W-1:0]  sub_cnt;      // cycles within the current centimetre
    logic [DIST_W-1:0] cm_cnt;       // centimetres already emitted
    logic [DIST_W-1:0] cm_target;    // clamped latched distance
    logic              timeout_sel;  // latched "no object / out of range"
    logic [TW-1:0]     trig_width;

    // Echo length decision taken from the live inputs at acceptance time;
    // only the registered copies steer the pulse afterwards.
    logic              accept_timeout;
    logic [DIST_W-1:0] accept_cm;
    logic              echo_done;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        accept_timeout = 1'b0;
        accept_cm      = distance_cm;
        echo_done      = 1'b0;

        if (!object_present || (distance_cm > DIST_MAX)) begin
            accept_timeout = 1'b1;
        end
        if (distance_cm < DIST_MIN) begin
            accept_cm = DIST_MIN;
        end

        // Last echo-high cycle: either the flat timeout count or the final
        // sub-cycle of the final centimetre.
        if (timeout_sel) begin
            echo_done = (cnt == TIMEOUT_LAST);
        end else begin
            echo_done = (sub_cnt == SUB_LAST) &&
                        (cm_cnt == cm_target - DIST_W'(1));
        end
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: every flop here, including the latched distance, is cleared by the
    // asynchronous reset; that also drops echo immediately mid-pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            echo         <= 1'b0;
            busy         <= 1'b0;
            short_trig   <= 1'b0;
            trig_ignored <= 1'b0;
            meas_count   <= 16'd0;
            cnt          <= '0;
            sub_cnt      <= '0;
            cm_cnt       <= '0;
            cm_target    <= '0;
            timeout_sel  <= 1'b0;
            trig_width   <= '0;
        end else begin
            short_trig   <= 1'b0;
            trig_ignored <= 1'b0;

            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state      <= TRIG_HI;
                        trig_width <= TW'(1);
                    end
                end

                TRIG_HI: begin
                    if (trig_fall) begin
                        if (trig_width >= TRIG_MIN) begin
                            state       <= BURST;
                            busy        <= 1'b1;
                            cnt         <= '0;
                            timeout_sel <= accept_timeout;
                            cm_target   <= accept_cm;
                        end else begin
                            state      <= IDLE;
                            short_trig <= 1'b1;
                        end
                    end else if (trig_level && (trig_width < TRIG_MIN)) begin
                        // Saturates so a stuck-high trigger never wraps.
                        trig_width <= trig_width + TW'(1);
                    end
                end

                BURST: begin
                    trig_ignored <= trig_rise;
                    if (cnt == BURST_LAST) begin
                        state   <= ECHO;
                        echo    <= 1'b1;
                        cnt     <= '0;
                        sub_cnt <= '0;
                        cm_cnt  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ECHO: begin
                    trig_ignored <= trig_rise;
                    if (echo_done) begin
                        state      <= HOLDOFF;
                        echo       <= 1'b0;
                        meas_count <= meas_count + 16'd1;
                        cnt        <= '0;
                    end else if (timeout_sel) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (sub_cnt == SUB_LAST) begin
                        // Nested counting replaces a distance multiplier.
                        sub_cnt <= '0;
                        cm_cnt  <= cm_cnt + DIST_W'(1);
                    end else begin
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end
                end

                HOLDOFF: begin
                    trig_ignored <= trig_rise;
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : hcsr04_echo_emulator

// File: tb/tb_hcsr04_echo_emulator.sv
// -----------------------------------------------------------------------------
// tb_hcsr04_echo_emulator
//
// Directed plus randomized bench for hcsr04_echo_emulator. Inputs are driven
// and outputs sampled on the falling clock edge. Expected echo widths, echo
// latency, holdoff length and completed-measurement counts come from the
// protocol rules written as plain arithmetic below.
// -----------------------------------------------------------------------------
module tb_hcsr04_echo_emulator;

    localparam int TRIG_MIN_CYC  = 5;
    localparam int BURST_DLY_CYC = 20;
    localparam int CYC_PER_CM    = 10;
    localparam int MIN_CM        = 2;
    localparam int MAX_CM        = 400;
    localparam int TIMEOUT_CYC   = 5000;
    localparam int HOLDOFF_CYC   = 50;
    localparam int DIST_W        = 9;

    // Echo first seen high this many falling edges after trig drops at the pin:
    // rise lands on rising edge 3+BURST_DLY_CYC, visible on the next falling edge.
    localparam int RISE_LAT = 3 + BURST_DLY_CYC + 1;
    localparam int LIMIT    = RISE_LAT + TIMEOUT_CYC + HOLDOFF_CYC + 50;

    logic              clk;
    logic              rst_n;
    logic              trig;
    logic [DIST_W-1:0] distance_cm;
    logic              object_present;
    logic              echo;
    logic              busy;
    logic              short_trig;
    logic              trig_ignored;
    logic [15:0]       meas_count;

    int vectors;
    int miscompares;
    int short_cnt;
    int ign_cnt;
    int exp_meas;

    hcsr04_echo_emulator #(
        .TRIG_MIN_CYC  (TRIG_MIN_CYC),
        .BURST_DLY_CYC (BURST_DLY_CYC),
        .CYC_PER_CM    (CYC_PER_CM),
        .MIN_CM        (MIN_CM),
        .MAX_CM        (MAX_CM),
        .TIMEOUT_CYC   (TIMEOUT_CYC),
        .HOLDOFF_CYC   (HOLDOFF_CYC),
        .DIST_W        (DIST_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trig           (trig),
        .distance_cm    (distance_cm),
        .object_present (object_present),
        .echo           (echo),
        .busy           (busy),
        .short_trig     (short_trig),
        .trig_ignored   (trig_ignored),
        .meas_count     (meas_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors: a one-cycle pulse is counted once per falling edge.
    always @(negedge clk) begin
        if (short_trig)   short_cnt++;
        if (trig_ignored) ign_cnt++;
    end

    // Reference echo width from the protocol rules.
    function automatic int exp_len(input int d, input bit obj);
        if (!obj || d > MAX_CM) return TIMEOUT_CYC;
        return ((d < MIN_CM) ? MIN_CM : d) * CYC_PER_CM;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full measurement. d_new >= 0 changes distance_cm during BURST.
    // hold_mode: 0 none, 1 short poke in holdoff, 2 raise trig in holdoff and
    // keep it high past the end of holdoff.
    task automatic measure(input string name, input int hi, input int d,
                           input bit obj, input int d_new,
                           input bit poke_echo, input int hold_mode);
        int  exp_l;
        int  n_r;
        int  n_f;
        int  n_b;
        int  ign0;
        int  sh0;
        bit  busy_ok;
        bit  stray;
        exp_l   = exp_len(d, obj);
        ign0    = ign_cnt;
        sh0     = short_cnt;
        n_r     = -1;
        n_f     = -1;
        n_b     = -1;
        busy_ok = 1'b1;

        distance_cm    = DIST_W'(d);
        object_present = obj;
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;

        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (k == 5 && d_new >= 0) distance_cm = DIST_W'(d_new);
            if (n_r < 0) begin
                if (echo) n_r = k;
                if (k >= 3 && !busy) busy_ok = 1'b0;
            end else if (n_f < 0) begin
                if (poke_echo && k == n_r + 5) trig = 1'b1;
                if (poke_echo && k == n_r + 7) trig = 1'b0;
                if (!echo) n_f = k;
                if (!busy) busy_ok = 1'b0;
            end else begin
                if (hold_mode != 0 && k == n_f + 10) trig = 1'b1;
                if (hold_mode == 1 && k == n_f + 12) trig = 1'b0;
                if (!busy) begin
                    n_b = k;
                    break;
                end
            end
        end
        exp_meas = (exp_meas + 1) & 16'hFFFF;

        check({name, "_rise_latency"}, n_r, RISE_LAT);
        check({name, "_echo_width"}, (n_r < 0 || n_f < 0) ? -1 : n_f - n_r, exp_l);
        check({name, "_holdoff"}, (n_f < 0 || n_b < 0) ? -1 : n_b - n_f, HOLDOFF_CYC);
        check({name, "_busy_held"}, busy_ok, 1);

        // trig still high after holdoff must not arm a new measurement.
        stray = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || echo) stray = 1'b1;
        end
        if (hold_mode == 2) begin
            trig = 1'b0;
            repeat (6) @(negedge clk);
        end
        check({name, "_no_rearm"}, stray, 0);
        check({name, "_meas_count"}, meas_count, exp_meas);
        check({name, "_ignored"}, ign_cnt - ign0,
              (poke_echo ? 1 : 0) + ((hold_mode != 0) ? 1 : 0));
        check({name, "_no_short"}, short_cnt - sh0, 0);
    endtask

    task automatic short_pulse(input string name, input int hi);
        int sh0;
        bit saw_echo;
        bit saw_busy;
        sh0      = short_cnt;
        saw_echo = 1'b0;
        saw_busy = 1'b0;
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (echo) saw_echo = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check({name, "_short_pulses"}, short_cnt - sh0, 1);
        check({name, "_echo_idle"}, saw_echo, 0);
        check({name, "_busy_idle"}, saw_busy, 0);
        check({name, "_meas_count"}, meas_count, exp_meas);
    endtask

    initial begin
        int rd;
        int rh;
        bit ro;
        vectors        = 0;
        miscompares    = 0;
        short_cnt      = 0;
        ign_cnt        = 0;
        exp_meas       = 0;
        rst_n          = 1'b0;
        trig           = 1'b0;
        distance_cm    = '0;
        object_present = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_echo", echo, 0);
        check("reset_busy", busy, 0);
        check("reset_short_trig", short_trig, 0);
        check("reset_trig_ignored", trig_ignored, 0);
        check("reset_meas_count", meas_count, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic valid measurement
        measure("valid25", 8, 25, 1'b1, -1, 1'b0, 0);

        // Trigger width boundary
        short_pulse("short3", 3);
        short_pulse("short4", TRIG_MIN_CYC - 1);
        measure("trigmin", TRIG_MIN_CYC, 10, 1'b1, -1, 1'b0, 0);

        // Clamping and range
        measure("dist0", 6, 0, 1'b1, -1, 1'b0, 0);
        measure("dist1", 6, 1, 1'b1, -1, 1'b0, 0);
        measure("dist400", 6, 400, 1'b1, -1, 1'b0, 0);
        measure("dist401", 6, 401, 1'b1, -1, 1'b0, 0);
        measure("noobj", 6, 10, 1'b0, -1, 1'b0, 0);

        // Retrigger while busy, then a normal follow-up
        measure("retrig", 8, 25, 1'b1, -1, 1'b1, 1);
        measure("after_retrig", 7, 12, 1'b1, -1, 1'b0, 0);

        // Latched distance survives an input change during BURST
        measure("latch", 8, 30, 1'b1, 5, 1'b0, 0);

        // trig held high across the end of holdoff
        measure("hold_high", 8, 3, 1'b1, -1, 1'b0, 2);

        // Randomized measurements
        for (int i = 0; i < 4; i++) begin
            rd = $urandom_range(0, 450);
            rh = $urandom_range(TRIG_MIN_CYC, TRIG_MIN_CYC + 8);
            ro = ($urandom_range(0, 4) != 0);
            measure($sformatf("rand%0d", i), rh, rd, ro, -1,
                    (exp_len(rd, ro) > 12), 0);
        end

        // Asynchronous reset in the middle of an echo
        distance_cm    = DIST_W'(100);
        object_present = 1'b1;
        trig = 1'b1;
        repeat (8) @(negedge clk);
        trig = 1'b0;
        for (int k = 0; k < RISE_LAT + 10; k++) begin
            @(negedge clk);
            if (echo) break;
        end
        check("areset_pre_echo", echo, 1);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_echo", echo, 0);
        check("areset_busy", busy, 0);
        check("areset_meas_count", meas_count, 0);
        exp_meas = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        measure("post_reset", 8, 25, 1'b1, -1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_hcsr04_echo_emulator
